readout_arbiter: RTL

READOUT_ARBITER -- requirements
Module: readout_arbiter

---
 rtl/readout_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/readout_arbiter.sv
// Round-robin readout of two source FIFOs into a header-tagged byte stream.
// Each packet is one header byte followed by the source word, MSB byte first.
module readout_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter logic [7:0]  HDR0   = 8'hA5,
  parameter logic [7:0]  HDR1   = 8'hA6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        src_enable,
  input  logic              src0_empty,
  input  logic              src1_empty,
  output logic              src0_rd_en,
  output logic              src1_rd_en,
  input  logic [DATA_W-1:0] src0_data,
  input  logic [DATA_W-1:0] src1_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       word_count0,
  output logic [15:0]       word_count1
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, HEADER, DATA} state_t;

  state_t            state, state_next;
  logic              grant, grant_next;
  logic              last_grant;
  logic [1:0]        pending;
  logic              handshake;
  logic              last_byte;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;

  assign pending   = src_enable & {~src1_empty, ~src0_empty};
  assign handshake = out_valid & out_ready;
  assign last_byte = (byte_idx == LAST_IDX);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    grant_next = grant;
    src0_rd_en = 1'b0;
    src1_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = READ;
          // on contention the source that did not go last wins
          grant_next = (&pending) ? ~last_grant : pending[1];
        end
      end
      READ: begin
        src0_rd_en = ~grant;
        src1_rd_en = grant;
        state_next = LATCH;
      end
      LATCH:   state_next = HEADER;
      HEADER:  if (handshake) state_next = DATA;
      DATA:    if (handshake && last_byte) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      byte_idx    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      last_grant  <= 1'b1;
      word_count0 <= '0;
      word_count1 <= '0;
    end else begin
      case (state)
        LATCH: begin
          shreg     <= grant ? src1_data : src0_data;
          out_valid <= 1'b1;
          out_data  <= grant ? HDR1 : HDR0;
        end
        HEADER: begin
          if (handshake) begin
            out_data <= shreg[DATA_W-1 -: 8];
            shreg    <= shreg << 8;
            byte_idx <= '0;
          end
        end
        DATA: begin
          if (handshake) begin
            if (last_byte) begin
              out_valid  <= 1'b0;
              last_grant <= grant;
              if (grant) word_count1 <= word_count1 + 16'd1;
              else       word_count0 <= word_count0 + 16'd1;
            end else begin
              out_data <= shreg[DATA_W-1 -: 8];
              shreg    <= shreg << 8;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
